// File: rtl/dcmi_capture_ctrl_if.sv
// Config, event and status signals between the DCMI capture sequencer and its surroundings.
interface dcmi_capture_ctrl_if #(
    parameter int unsigned FCNT_W = 16
);
    logic              cfg_capture;
    logic              cfg_cm;
    logic [1:0]        cfg_fcrc;
    logic              frame_start;
    logic              frame_end;
    logic              cnt_clr;
    logic              capture_active;
    logic              frame_done;
    logic              capture_clr;
    logic              sync_err;
    logic              busy;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output cfg_capture, cfg_cm, cfg_fcrc, frame_start, frame_end, cnt_clr,
        input  capture_active, frame_done, capture_clr, sync_err, busy, frame_cnt
    );

    modport slave (
        input  cfg_capture, cfg_cm, cfg_fcrc, frame_start, frame_end, cnt_clr,
        output capture_active, frame_done, capture_clr, sync_err, busy, frame_cnt
    );
endinterface

// File: rtl/dcmi_capture_ctrl.sv
// Frame-level capture sequencer: gates the pixel datapath per frame, applies
// frame-rate decimation, and counts captured frames.
module dcmi_capture_ctrl #(
    parameter int unsigned FCNT_W = 16
) (
    input  logic                clk,
    input  logic                rstn,
    dcmi_capture_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SKIP  = 2'd2,
        CAPT  = 2'd3
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [1:0]        phase_q;
    logic [1:0]        phase_d;
    logic              take_c;
    logic              start_eval;
    logic              done_d;
    logic              clr_d;
    logic              err_d;

    logic              capture_active_d;
    logic              busy_d;
    logic [FCNT_W-1:0] frame_cnt_d;

    logic              capture_active_q;
    logic              frame_done_q;
    logic              capture_clr_q;
    logic              sync_err_q;
    logic              busy_q;
    logic [FCNT_W-1:0] frame_cnt_q;

    // Decimation decision for a frame_start evaluated as if in ARMED
    always_comb begin
        case (bus.cfg_fcrc)
            2'b01:   take_c = ~phase_q[0];
            2'b10:   take_c = (phase_q == 2'd0);
            default: take_c = 1'b1;
        endcase
    end

    // Next-state: frame_end is resolved first, a coincident frame_start is then evaluated from ARMED
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        start_eval = 1'b0;
        done_d     = 1'b0;
        clr_d      = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_capture) begin
                    state_d = ARMED;
                    phase_d = 2'd0;
                end
            end
            ARMED: begin
                if (!bus.cfg_capture) begin
                    state_d = IDLE;
                end else if (bus.frame_start) begin
                    start_eval = 1'b1;
                end
            end
            SKIP: begin
                if (!bus.cfg_capture) begin
                    state_d = IDLE;
                end else if (bus.frame_end) begin
                    state_d    = ARMED;
                    start_eval = bus.frame_start;
                end
            end
            CAPT: begin
                if (bus.frame_end) begin
                    done_d = 1'b1;
                    if (bus.cfg_cm) begin
                        clr_d   = 1'b1;
                        state_d = IDLE;
                    end else if (!bus.cfg_capture) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = ARMED;
                        start_eval = bus.frame_start;
                    end
                end else if (bus.frame_start) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_eval) begin
            phase_d = phase_q + 2'd1;
            state_d = take_c ? CAPT : SKIP;
        end
    end

    // Output next values; gate and busy follow the state being entered so they line up with it
    always_comb begin
        capture_active_d = (state_d == CAPT);
        busy_d           = (state_d != IDLE);
        frame_cnt_d      = frame_cnt_q;
        if (bus.cnt_clr) begin
            frame_cnt_d = '0;
        end else if (done_d) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end
    end

    // State, phase and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= IDLE;
            phase_q          <= 2'd0;
            capture_active_q <= 1'b0;
            frame_done_q     <= 1'b0;
            capture_clr_q    <= 1'b0;
            sync_err_q       <= 1'b0;
            busy_q           <= 1'b0;
            frame_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            phase_q          <= phase_d;
            capture_active_q <= capture_active_d;
            frame_done_q     <= done_d;
            capture_clr_q    <= clr_d;
            sync_err_q       <= err_d;
            busy_q           <= busy_d;
            frame_cnt_q      <= frame_cnt_d;
        end
    end

    assign bus.capture_active = capture_active_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.capture_clr    = capture_clr_q;
    assign bus.sync_err       = sync_err_q;
    assign bus.busy           = busy_q;
    assign bus.frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_dcmi_capture_ctrl.sv
// Self-checking bench for dcmi_capture_ctrl: behavioural frame model compared every cycle,
// directed scenarios with hand-computed frame counts, then randomized traffic.
module tb_dcmi_capture_ctrl;

    logic clk = 1'b0;
    logic rstn;

    dcmi_capture_ctrl_if #(.FCNT_W(16)) bus ();

    dcmi_capture_ctrl #(.FCNT_W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: "enabled", "capturing", "skipping" flags plus a running frame index
    bit        m_on;
    bit        m_cap;
    bit        m_skip;
    int        m_seq;
    bit        m_inc;
    bit        m_start;
    int        m_div;
    logic      e_done;
    logic      e_clr;
    logic      e_err;
    logic [15:0] e_cnt;

    // Literal pins requested by the stimulus, checked by the compare process
    int          pin_seq = 0;
    int          pin_done = 0;
    logic [15:0] pin_val;
    string       pin_name;

    // Model update on the same edge the DUT samples its inputs
    always @(posedge clk) begin
        e_done = 1'b0;
        e_clr  = 1'b0;
        e_err  = 1'b0;
        if (!rstn) begin
            m_on   = 1'b0;
            m_cap  = 1'b0;
            m_skip = 1'b0;
            m_seq  = 0;
            e_cnt  = 16'd0;
        end else begin
            m_inc   = 1'b0;
            m_start = 1'b0;
            if (!m_on) begin
                if (bus.cfg_capture) begin
                    m_on  = 1'b1;
                    m_seq = 0;
                end
            end else if (m_cap) begin
                if (bus.frame_end) begin
                    e_done = 1'b1;
                    m_inc  = 1'b1;
                    m_cap  = 1'b0;
                    if (bus.cfg_cm) begin
                        e_clr = 1'b1;
                        m_on  = 1'b0;
                    end else if (!bus.cfg_capture) begin
                        m_on = 1'b0;
                    end else begin
                        m_start = bus.frame_start;
                    end
                end else if (bus.frame_start) begin
                    e_err = 1'b1;
                end
            end else if (!bus.cfg_capture) begin
                m_on   = 1'b0;
                m_skip = 1'b0;
            end else if (m_skip) begin
                if (bus.frame_end) begin
                    m_skip  = 1'b0;
                    m_start = bus.frame_start;
                end
            end else begin
                m_start = bus.frame_start;
            end
            if (m_start) begin
                m_div = (bus.cfg_fcrc == 2'b01) ? 2 : (bus.cfg_fcrc == 2'b10) ? 4 : 1;
                if ((m_seq % m_div) == 0) m_cap = 1'b1;
                else                      m_skip = 1'b1;
                m_seq = m_seq + 1;
            end
            if (bus.cnt_clr)    e_cnt = 16'd0;
            else if (m_inc)     e_cnt = e_cnt + 16'd1;
        end
    end

    task automatic chk(input logic [15:0] act, input logic [15:0] exp, input string name);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        chk(16'(bus.capture_active), 16'(m_cap),  "capture_active");
        chk(16'(bus.frame_done),     16'(e_done), "frame_done");
        chk(16'(bus.capture_clr),    16'(e_clr),  "capture_clr");
        chk(16'(bus.sync_err),       16'(e_err),  "sync_err");
        chk(16'(bus.busy),           16'(m_on),   "busy");
        chk(bus.frame_cnt,           e_cnt,       "frame_cnt");
        if (pin_seq != pin_done) begin
            chk(bus.frame_cnt, pin_val, {"pin_dut_", pin_name});
            chk(e_cnt,         pin_val, {"pin_model_", pin_name});
            pin_done = pin_seq;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input logic [15:0] v, input string name);
        pin_val  = v;
        pin_name = name;
        pin_seq  = pin_seq + 1;
    endtask

    // One frame: start at T, end at T+len
    task automatic frame(input int len);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (len - 1) tick();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
    endtask

    task automatic clear_cnt();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
    endtask

    initial begin
        rstn            = 1'b0;
        bus.cfg_capture = 1'b0;
        bus.cfg_cm      = 1'b0;
        bus.cfg_fcrc    = 2'b00;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.cnt_clr     = 1'b0;
        repeat (3) tick();
        pin(16'd0, "reset");
        rstn = 1'b1;

        // Continuous, all frames
        bus.cfg_capture = 1'b1;
        tick();
        repeat (3) begin
            frame(100);
            repeat (4) tick();
        end
        pin(16'd3, "continuous3");

        // Snapshot: only the first of two frames is taken
        clear_cnt();
        bus.cfg_cm = 1'b1;
        frame(20);
        tick();
        bus.cfg_capture = 1'b0;
        frame(20);
        tick();
        pin(16'd1, "snapshot");
        bus.cfg_cm = 1'b0;

        // Decimation 1 of 4, then 1 of 2, over 8 frames each
        clear_cnt();
        bus.cfg_fcrc    = 2'b10;
        bus.cfg_capture = 1'b1;
        tick();
        repeat (8) begin frame(10); tick(); end
        pin(16'd2, "fcrc10");
        bus.cfg_capture = 1'b0;
        tick();
        clear_cnt();
        bus.cfg_fcrc    = 2'b01;
        bus.cfg_capture = 1'b1;
        tick();
        repeat (8) begin frame(10); tick(); end
        pin(16'd4, "fcrc01");
        bus.cfg_fcrc = 2'b00;

        // Enable dropped mid-capture completes the frame; dropped in ARMED returns to IDLE
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        bus.cfg_capture = 1'b0;
        repeat (3) tick();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        repeat (2) tick();
        pin(16'd5, "drop_capt");
        bus.cfg_capture = 1'b1;
        tick();
        bus.cfg_capture = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (3) tick();
        pin(16'd5, "drop_armed");

        // sync_err on a stray frame_start, then back-to-back frames with no gap
        bus.cfg_capture = 1'b1;
        tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (3) tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (2) tick();
        bus.frame_end   = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        repeat (3) tick();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        tick();
        pin(16'd7, "sync_b2b");

        // Counter wrap: 65535 single-cycle frames, then one more
        clear_cnt();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_end = 1'b1;
        repeat (65535) tick();
        pin(16'hFFFF, "cnt_max");
        bus.frame_start = 1'b0;
        tick();
        bus.frame_end = 1'b0;
        pin(16'h0000, "cnt_wrap");
        tick();

        // Clear coincident with an increment, then reset mid-frame
        frame(5);
        tick();
        pin(16'd1, "pre_clr");
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b1;
        bus.cnt_clr     = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        bus.cnt_clr   = 1'b0;
        pin(16'd0, "clr_wins");
        frame(3);
        tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        pin(16'd0, "reset_mid");
        rstn = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.cfg_capture = ~bus.cfg_capture;
            if ($urandom_range(0, 99) == 0) bus.cfg_cm      = ~bus.cfg_cm;
            if ($urandom_range(0, 59) == 0) bus.cfg_fcrc    = 2'($urandom_range(0, 3));
            bus.frame_start = ($urandom_range(0, 7) == 0);
            bus.frame_end   = ($urandom_range(0, 7) == 0);
            bus.cnt_clr     = ($urandom_range(0, 63) == 0);
            rstn            = ($urandom_range(0, 299) != 0);
            tick();
        end
        rstn            = 1'b1;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.cnt_clr     = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
